// File: rtl/memory_pipe.sv
// memory_pipe: single-port word memory with byte-enable writes, a fixed-latency
// read pipeline and a self-clearing walk that zeroes the array after reset or
// on request.
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   reset      - synchronous active-high reset (forces a fresh clear walk)
//   wr_en      - write request, taken only while ready=1
//   rd_en      - read request, taken only while ready=1
//   addr       - word address shared by read and write
//   wr_be      - byte enables, bit i selects datain[8i+7:8i]
//   datain     - write data
//   clear_req  - one-cycle request to zero the whole array (ignored while clearing)
//   dataout    - read data, forced to 0 whenever DataValid=0
//   DataValid  - one-cycle pulse per returned read, READ_LATENCY cycles after acceptance
//   ready      - high while requests are accepted (IDLE)
module memory_pipe #(
    parameter int DATAWIDTH    = 32,
    parameter int ADDRWIDTH    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [ADDRWIDTH-1:0]   addr,
    input  logic [DATAWIDTH/8-1:0] wr_be,
    input  logic [DATAWIDTH-1:0]   datain,
    input  logic                   clear_req,
    output logic [DATAWIDTH-1:0]   dataout,
    output logic                   DataValid,
    output logic                   ready
);

    localparam int BYTES = DATAWIDTH / 8;
    localparam int DEPTH = 1 << ADDRWIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                 state;
    logic [ADDRWIDTH-1:0]   clr_cnt;
    logic [DATAWIDTH-1:0]   mem [DEPTH];

    // Stage i of the read pipeline; the last stage drives the outputs.
    logic [DATAWIDTH-1:0]    rd_data_p [READ_LATENCY];
    logic [READ_LATENCY-1:0] rd_vld_p;

    logic wr_acc;
    logic rd_acc;

    assign wr_acc = ready & wr_en;
    assign rd_acc = ready & rd_en;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [DATAWIDTH-1:0] merge_bytes(
        input logic [DATAWIDTH-1:0] old_word,
        input logic [DATAWIDTH-1:0] new_word,
        input logic [BYTES-1:0]     be
    );
        logic [DATAWIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < BYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Control FSM; ready is registered alongside the state so it is high
    // exactly while the FSM sits in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == '1) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Array storage: the clear walk owns the write port while clearing,
    // otherwise accepted writes merge bytes. No write happens under reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_acc) begin
                mem[addr] <= merge_bytes(mem[addr], datain, wr_be);
            end
        end
    end

    // Stage p0 samples the array at the accepting edge (pre-write contents on
    // a same-address read+write); later stages only delay the word.
    always_ff @(posedge clk) begin
        rd_data_p[0] <= mem[addr];
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_data_p[i] <= rd_data_p[i-1];
        end
    end

    // Valid bits travel with the data; reset flushes in-flight reads while
    // a clear request leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p <= '0;
        end else begin
            rd_vld_p[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
        end
    end

    // Output stage
    assign DataValid = rd_vld_p[READ_LATENCY-1];
    assign dataout   = DataValid ? rd_data_p[READ_LATENCY-1] : '0;

endmodule

// File: tb/tb_memory_pipe.sv
// tb_memory_pipe: directed scoreboard bench for memory_pipe
// (DATAWIDTH=32, ADDRWIDTH=4, READ_LATENCY=2).
module tb_memory_pipe;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [3:0]    wr_be = '0;
    logic [DW-1:0] datain = '0;
    logic          clear_req = 1'b0;
    logic [DW-1:0] dataout;
    logic          DataValid;
    logic          ready;

    memory_pipe #(
        .DATAWIDTH   (DW),
        .ADDRWIDTH   (AW),
        .READ_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wr_be    (wr_be),
        .datain   (datain),
        .clear_req(clear_req),
        .dataout  (dataout),
        .DataValid(DataValid),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DataValid pulse must match the oldest expected read,
    // both in data and in the cycle it was due; idle cycles must show dataout=0.
    always @(negedge clk) begin
        if (DataValid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_datavalid actual=%h expected=none (cycle %0d)", dataout, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("read_data", dataout, e.data);
                check("read_cycle", cyc, e.due);
            end
        end else begin
            check("dataout_idle_zero", dataout, 32'h0);
        end
    end

    // One request cycle; when push=1 the bench expects a read response.
    task automatic issue(input logic w, input logic r, input logic clr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be,
                         input bit push, input logic [DW-1:0] exp);
        wr_en = w; rd_en = r; clear_req = clr; addr = a; datain = d; wr_be = be;
        if (push) q.push_back('{exp, cyc + LAT});
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0; clear_req = 0; wr_be = '0; datain = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        issue(1, 0, 0, a, d, be, 0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        issue(0, 1, 0, a, '0, '0, 1, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("reset_ready", {31'b0, ready}, 32'h0);
        check("reset_datavalid", {31'b0, DataValid}, 32'h0);
        check("reset_dataout", dataout, 32'h0);
    endtask

    // Expect 16 not-ready cycles then ready; with junk=1 hammer the block with
    // writes, reads and clear requests that must all be ignored.
    task automatic clear_window(input bit junk);
        for (int i = 0; i < 16; i++) begin
            check("ready_low", {31'b0, ready}, 32'h0);
            if (junk) begin
                wr_en = 1; rd_en = 1; clear_req = 1;
                addr = AW'(15 - i); datain = 32'h12345678; wr_be = 4'hF;
            end
            @(posedge clk); #1;
            wr_en = 0; rd_en = 0; clear_req = 0; wr_be = '0; datain = '0;
        end
        check("ready_high", {31'b0, ready}, 32'h1);
    endtask

    initial begin
        #2;
        // Power-up reset and full clear walk
        do_reset();
        clear_window(0);
        for (int i = 0; i < 16; i++) rd(AW'(i), 32'h0);
        idle(3);

        // Full and partial byte-enable writes
        wr(4'd3, 32'hDEADBEEF, 4'b1111);
        rd(4'd3, 32'hDEADBEEF);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3, 32'hDE22BE44);
        wr(4'd3, 32'hFFFFFFFF, 4'b0000);
        rd(4'd3, 32'hDE22BE44);
        wr(4'd3, 32'h00AB0000, 4'b0100);
        rd(4'd3, 32'hDEABBE44);

        // Read-before-write on the same address
        wr(4'd5, 32'hA5A5A5A5, 4'hF);
        issue(1, 1, 0, 4'd5, 32'h0, 4'hF, 1, 32'hA5A5A5A5);
        rd(4'd5, 32'h0);
        idle(3);

        // Fill with ones, then clear with a concurrent read of addr 7
        for (int i = 0; i < 16; i++) wr(AW'(i), 32'hFFFFFFFF, 4'hF);
        rd(4'd9, 32'hFFFFFFFF);
        issue(0, 1, 1, 4'd7, '0, '0, 1, 32'hFFFFFFFF);
        clear_window(1);
        for (int i = 0; i < 16; i++) rd(AW'(i), 32'h0);
        idle(3);

        // Reset while the clear counter is at 9 restarts the walk
        wr(4'd12, 32'h00000055, 4'hF);
        issue(0, 0, 1, 4'd0, '0, '0, 0, '0);
        idle(9);
        do_reset();
        clear_window(0);
        rd(4'd12, 32'h0);
        rd(4'd0, 32'h0);
        idle(3);

        // Reset flushes a read still in the pipeline
        wr(4'd3, 32'hCAFEF00D, 4'hF);
        issue(0, 1, 0, 4'd3, '0, '0, 0, '0);
        do_reset();
        clear_window(0);
        rd(4'd3, 32'h0);
        idle(5);

        check("scoreboard_empty", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memory_pipe.md
MEMORY_PIPE -- requirements
Module: memory_pipe

Interface
REQ-001 The block SHALL expose parameter DATAWIDTH, default 32, word width in bits; legal values are multiples of 8.
REQ-002 The block SHALL expose parameter ADDRWIDTH, default 8, address width; depth = 2**ADDRWIDTH words.
REQ-003 The block SHALL expose parameter READ_LATENCY, default 2, accepted-read to DataValid delay in cycles; legal range 1..4.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-007 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-008 The block SHALL have port addr, input, ADDRWIDTH bits: word address, shared by read and write.
REQ-009 The block SHALL have port wr_be, input, DATAWIDTH/8 bits: byte enables; bit i controls datain[8i+7:8i].
REQ-010 The block SHALL have port datain, input, DATAWIDTH bits: write data.
REQ-011 The block SHALL have port clear_req, input, 1 bit: single-cycle request to zero the whole array.
REQ-012 The block SHALL have port dataout, output, DATAWIDTH bits: read data, qualified by DataValid.
REQ-013 The block SHALL have port DataValid, output, 1 bit: one-cycle pulse per returned read.
REQ-014 The block SHALL have port ready, output, 1 bit: high when requests are accepted (state IDLE).

Function
REQ-015 FSM SHALL have two states: CLEAR (walk counter over all addresses writing 0, one word per cycle) and IDLE (normal operation).
REQ-016 CLEAR SHALL write address = counter, counter 0 to 2**ADDRWIDTH-1, then go to IDLE; ready SHALL rise the cycle after address 2**ADDRWIDTH-1 is cleared.
REQ-017 In IDLE, clear_req=1 SHALL move the FSM to CLEAR with counter=0 on the next cycle; clear_req in CLEAR SHALL be ignored.
REQ-018 Requests SHALL be accepted only when ready=1; wr_en/rd_en with ready=0 SHALL cause no write and no DataValid.
REQ-019 An accepted write SHALL update only bytes whose wr_be bit is 1, taking effect at that clock edge; wr_be=0 SHALL leave the word unchanged.
REQ-020 An accepted read in cycle N SHALL sample the array in cycle N and present the word with DataValid=1 in cycle N+READ_LATENCY; reads pipeline back-to-back, one per cycle.
REQ-021 Simultaneous accepted rd_en and wr_en to the same address SHALL return the pre-write data (read-before-write) and perform the write.
REQ-022 Reads in flight when clear_req is taken SHALL complete at their scheduled cycles with the data sampled at acceptance.
REQ-023 When DataValid=0, dataout SHALL be 0.
REQ-024 Address wrap: addr is exactly ADDRWIDTH bits; no out-of-range access exists; the clear counter SHALL not exceed 2**ADDRWIDTH-1.

Reset
REQ-025 reset=1 at a rising edge SHALL set state=CLEAR, counter=0, ready=0, DataValid=0, dataout=0, and flush all in-flight reads.
REQ-026 reset SHALL take priority over clear_req, wr_en and rd_en in the same cycle; reset mid-CLEAR SHALL restart the walk at address 0.
REQ-027 After reset deasserts, ready SHALL go high exactly 2**ADDRWIDTH cycles later and every word SHALL read 0.

Verification (DATAWIDTH=32, ADDRWIDTH=4, READ_LATENCY=2)
REQ-028 Reset 1 cycle, release -> ready=0 for 16 cycles then 1; reads of addr 0..15 -> DataValid 2 cycles after each, dataout=0.
REQ-029 Write addr 3 = 0xDEADBEEF, wr_be=4'b1111; read addr 3 -> DataValid at N+2, dataout=0xDEADBEEF.
REQ-030 Write addr 3 = 0x11223344, wr_be=4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-031 Same cycle rd_en+wr_en addr 5, old 0xA5A5A5A5, new 0x0 -> dataout=0xA5A5A5A5; next read returns 0x0.
REQ-032 clear_req after filling memory with 0xFFFFFFFF, rd_en addr 7 in same cycle -> that read returns 0xFFFFFFFF; ready low 16 cycles; writes during CLEAR dropped; later reads return 0.
REQ-033 reset asserted at counter=9 during CLEAR -> walk restarts at 0; ready rises 16 cycles after reset release; in-flight reads produce no DataValid.
